// File: rtl/vga_mem_pkg.sv
// Shared definitions for the frame-SRAM arbiter: default bus widths,
// arbiter state encoding and the packed write-request record.
package vga_mem_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bundle of the display fetch path, the buffered write port and the SRAM
// pins. The arbiter sits on the slave side; the system/bench on the master side.
//
// Write handshake: a write is accepted at a rising clk edge where
// wr_valid && wr_ready && clk_en are all high. wr_ready depends only on the
// registered queue level, never on wr_valid, so a master may hold wr_valid
// with stable wr_addr/wr_data until it sees an accepting edge.
interface vga_mem_arbiter_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = vga_mem_pkg::ADDR_W,
    parameter int DATA_W     = vga_mem_pkg::DATA_W
);
    import vga_mem_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              clk_en;
    logic              pix_en;
    logic              video_off;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LW-1:0]     fifo_level;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              mem_oe;
    arb_state_t        state;

    modport slave (
        input  clk_en, pix_en, video_off, vga_addr,
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output vga_data, wr_ready, fifo_level,
        output mem_addr, mem_wdata, mem_we, mem_oe, state
    );

    modport master (
        output clk_en, pix_en, video_off, vga_addr,
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  vga_data, wr_ready, fifo_level,
        input  mem_addr, mem_wdata, mem_we, mem_oe, state
    );

endinterface

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO holding pending pixel writes in acceptance order.
// Push and pop may happen in the same cycle; the level is then unchanged.
module vga_wr_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 27
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        full
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] store [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level != '0);
    assign dout    = store[rd_ptr];

    // Entry storage: written on push, no reset needed since level gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Time-slot arbiter for the single-port frame SRAM. Pixel phases in active
// video belong to the display read; every other enabled cycle drains one
// queued write. All SRAM pins are registered.
module vga_mem_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = vga_mem_pkg::ADDR_W,
    parameter int DATA_W     = vga_mem_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    vga_mem_arbiter_if.slave bus
);
    import vga_mem_pkg::*;

    localparam int QW = ADDR_W + DATA_W;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic              we_q;
    logic              we_d;
    logic              oe_q;
    logic              oe_d;
    logic [DATA_W-1:0] vga_data_q;
    logic              push;
    logic              pop;
    logic              full;
    logic [QW-1:0]     head;

    // No pass-through when full: ready looks only at the registered level.
    assign push         = bus.wr_valid && !full && bus.clk_en;
    assign bus.wr_ready = !full;

    vga_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (QW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.wr_addr, bus.wr_data}),
        .dout  (head),
        .level (bus.fifo_level),
        .full  (full)
    );

    // Slot decision: display read first, then a queued write, else idle.
    always_comb begin
        state_d = IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        pop     = 1'b0;
        if (bus.clk_en) begin
            if (bus.pix_en && !bus.video_off) begin
                state_d = RD;
                addr_d  = bus.vga_addr;
                oe_d    = 1'b1;
            end else if (bus.fifo_level != '0) begin
                state_d = WR;
                addr_d  = head[QW-1 -: ADDR_W];
                wdata_d = head[DATA_W-1:0];
                we_d    = 1'b1;
                pop     = 1'b1;
            end
        end
    end

    // State and SRAM pin registers; a low clk_en truncates the op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
        end
    end

    // Capture read data at the edge that ends a completed read slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_data_q <= '0;
        end else if (bus.clk_en && state_q == RD) begin
            vga_data_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_oe    = oe_q;
    assign bus.vga_data  = vga_data_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: table of hand-computed cycles, hand-written
// reset/truncation sequences and a randomised run, all checked against a
// write queue / read queue scoreboard and a queue-level model.
module tb_vga_mem_arbiter;
  import vga_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW = 19;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_mem_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  vga_mem_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Asynchronous SRAM read model.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return (a == 19'h12345) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  assign bus.mem_rdata = bus.mem_oe ? rd_model(bus.mem_addr) : 8'h00;

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_wq[$];
  logic [AW-1:0]    exp_rq[$];
  logic [2:0]       lvl;
  logic             rd_pend;
  logic [DW-1:0]    rd_exp;
  logic [DW-1:0]    vga_exp;
  int               tests = 0;
  int               fails = 0;

  typedef struct {
    logic          ce, pix, voff, wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] va;
    logic          oe, we;
    logic [2:0]    lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ce, pix, voff, wv, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [AW-1:0] va,
                              input logic oe, we, input logic [2:0] l);
    vec_t v;
    v.ce = ce; v.pix = pix; v.voff = voff; v.wv = wv;
    v.wa = wa; v.wd = wd; v.va = va; v.oe = oe; v.we = we; v.lvl = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observe the bus after an edge and retire scoreboard entries.
  task automatic monitor();
    logic [AW+DW-1:0] w;
    logic [AW-1:0]    ra;
    check("we_oe_exclusive", {31'b0, bus.mem_we & bus.mem_oe}, 32'd0);
    if (bus.mem_we) begin
      check("write_expected", {31'b0, exp_wq.size() != 0}, 32'd1);
      if (exp_wq.size() != 0) begin
        w = exp_wq.pop_front();
        check("mem_addr_wr", bus.mem_addr, w[AW+DW-1:DW]);
        check("mem_wdata", bus.mem_wdata, w[DW-1:0]);
      end
    end
    if (rd_pend) vga_exp = rd_exp;
    check("vga_data", bus.vga_data, vga_exp);
    rd_pend = 1'b0;
    if (bus.mem_oe) begin
      check("read_expected", {31'b0, exp_rq.size() != 0}, 32'd1);
      if (exp_rq.size() != 0) begin
        ra = exp_rq.pop_front();
        check("mem_addr_rd", bus.mem_addr, ra);
        rd_pend = 1'b1;
        rd_exp  = rd_model(ra);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, ce, pix, voff, wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] va);
    logic acc, pop_m, rd_m;
    rst           = r;
    bus.clk_en    = ce;
    bus.pix_en    = pix;
    bus.video_off = voff;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.vga_addr  = va;
    if (!r) begin
      check("wr_ready", {31'b0, bus.wr_ready}, {31'b0, lvl != DEPTH});
      check("fifo_level", bus.fifo_level, lvl);
    end
    rd_m  = !r && ce && pix && !voff;
    pop_m = !r && ce && !rd_m && (lvl != 0);
    acc   = !r && ce && wv && (lvl != DEPTH);
    if (r) begin
      exp_wq.delete();
      exp_rq.delete();
      rd_pend = 1'b0;
      vga_exp = '0;
      lvl     = '0;
    end else begin
      if (acc) exp_wq.push_back({wa, wd});
      if (rd_m) exp_rq.push_back(va);
      if (!ce) rd_pend = 1'b0;
      if (acc && !pop_m) lvl = lvl + 3'd1;
      else if (!acc && pop_m) lvl = lvl - 3'd1;
    end
    @(posedge clk);
    @(negedge clk);
    check("mem_oe", {31'b0, bus.mem_oe}, {31'b0, rd_m});
    check("mem_we", {31'b0, bus.mem_we}, {31'b0, pop_m});
    monitor();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_vga_data"}, bus.vga_data, 32'd0);
    check({tag, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
    check({tag, "_mem_oe"}, {31'b0, bus.mem_oe}, 32'd0);
    check({tag, "_level"}, bus.fifo_level, 32'd0);
    check({tag, "_wr_ready"}, {31'b0, bus.wr_ready}, 32'd1);
    check({tag, "_state"}, {30'b0, bus.state}, {30'b0, IDLE});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic pix_r;
    logic voff_r;

    lvl = '0; rd_pend = 1'b0; rd_exp = '0; vga_exp = '0;

    // Cycle-by-cycle table: outputs after each edge, derived by hand.
    tbl.push_back(mk(1,1,0,0, 19'h0,    8'h0,  19'h12345, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 19'h0,    8'h0,  19'h12345, 0,0,0));
    tbl.push_back(mk(1,1,0,0, 19'h0,    8'h0,  19'h12345, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 19'h0,    8'h0,  19'h12345, 0,0,0));
    tbl.push_back(mk(1,1,0,1, 19'h10,   8'h11, 19'h00100, 1,0,1));
    tbl.push_back(mk(1,0,0,1, 19'h11,   8'h22, 19'h00100, 0,1,1));
    tbl.push_back(mk(1,1,0,1, 19'h12,   8'h33, 19'h00101, 1,0,2));
    tbl.push_back(mk(1,0,0,1, 19'h13,   8'h44, 19'h00101, 0,1,2));
    tbl.push_back(mk(1,1,0,0, 19'h0,    8'h0,  19'h00102, 1,0,2));
    tbl.push_back(mk(1,0,0,0, 19'h0,    8'h0,  19'h00102, 0,1,1));
    tbl.push_back(mk(1,1,0,0, 19'h0,    8'h0,  19'h00103, 1,0,1));
    tbl.push_back(mk(1,0,0,0, 19'h0,    8'h0,  19'h00103, 0,1,0));
    tbl.push_back(mk(1,1,0,0, 19'h0,    8'h0,  19'h00104, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 19'h0,    8'h0,  19'h00104, 0,0,0));
    tbl.push_back(mk(1,1,0,1, 19'h20,   8'hA0, 19'h00200, 1,0,1));
    tbl.push_back(mk(1,0,0,1, 19'h21,   8'hA1, 19'h00200, 0,1,1));
    tbl.push_back(mk(1,1,0,1, 19'h22,   8'hA2, 19'h00201, 1,0,2));
    tbl.push_back(mk(1,0,0,1, 19'h23,   8'hA3, 19'h00201, 0,1,2));
    tbl.push_back(mk(1,1,0,1, 19'h24,   8'hA4, 19'h00202, 1,0,3));
    tbl.push_back(mk(1,0,0,1, 19'h25,   8'hA5, 19'h00202, 0,1,3));
    tbl.push_back(mk(1,1,0,1, 19'h26,   8'hA6, 19'h00203, 1,0,4));
    tbl.push_back(mk(1,0,0,1, 19'h27,   8'hA7, 19'h00203, 0,1,3));
    tbl.push_back(mk(1,1,0,1, 19'h27,   8'hA7, 19'h00204, 1,0,4));
    tbl.push_back(mk(1,0,1,0, 19'h0,    8'h0,  19'h0,     0,1,3));
    tbl.push_back(mk(1,1,1,0, 19'h0,    8'h0,  19'h0,     0,1,2));
    tbl.push_back(mk(1,0,1,0, 19'h0,    8'h0,  19'h0,     0,1,1));
    tbl.push_back(mk(1,1,1,0, 19'h0,    8'h0,  19'h0,     0,1,0));
    tbl.push_back(mk(1,0,1,0, 19'h0,    8'h0,  19'h0,     0,0,0));
    tbl.push_back(mk(1,1,1,1, 19'h30,   8'hB0, 19'h0,     0,0,1));
    tbl.push_back(mk(1,0,1,1, 19'h31,   8'hB1, 19'h0,     0,1,1));
    tbl.push_back(mk(0,1,1,1, 19'h32,   8'hB2, 19'h0,     0,0,1));
    tbl.push_back(mk(0,1,1,0, 19'h0,    8'h0,  19'h0,     0,0,1));
    tbl.push_back(mk(1,1,1,0, 19'h0,    8'h0,  19'h0,     0,1,0));
    tbl.push_back(mk(1,0,1,0, 19'h0,    8'h0,  19'h0,     0,0,0));

    // Reset, then three idle cycles in blanking with nothing queued.
    step(1, 0, 0, 1, 0, '0, '0, '0);
    step(1, 0, 0, 1, 0, '0, '0, '0);
    check_all_zero("reset");
    for (int i = 0; i < 3; i++) step(0, 1, 1'(i % 2), 1, 0, '0, '0, '0);
    check_all_zero("idle");

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].ce, tbl[i].pix, tbl[i].voff, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].va);
      check("tbl_mem_oe", {31'b0, bus.mem_oe}, {31'b0, tbl[i].oe});
      check("tbl_mem_we", {31'b0, bus.mem_we}, {31'b0, tbl[i].we});
      check("tbl_level", bus.fifo_level, tbl[i].lvl);
      if (i == 1) check("vga_data_a5", bus.vga_data, 32'hA5);
    end

    // Queue three writes in active video, then reset: they must vanish.
    for (int i = 0; i < 5; i++)
      step(0, 1, 1'((i + 1) % 2), 0, 1, 19'h40 + 19'(i), 8'hC0 + 8'(i), 19'h300 + 19'(i));
    check("pre_reset_level", bus.fifo_level, 32'd3);
    step(1, 1, 0, 0, 1, 19'h4F, 8'hCF, '0);
    check("post_reset_level", bus.fifo_level, 32'd0);
    check("post_reset_ready", {31'b0, bus.wr_ready}, 32'd1);
    check("post_reset_we", {31'b0, bus.mem_we}, 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 1'(i % 2), 1, 0, '0, '0, '0);

    // Randomised mix of active/blanking, enable gaps and writes.
    pix_r  = 1'b1;
    voff_r = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic ce_r;
      if (c % 25 == 0) voff_r = 1'($urandom_range(0, 1));
      ce_r = ($urandom_range(0, 7) != 0);
      step(0, ce_r, pix_r, voff_r, 1'($urandom_range(0, 1)),
           19'($urandom_range(0, 19'h7FFFF)), 8'($urandom_range(0, 255)),
           19'($urandom_range(0, 19'h7FFFF)));
      if (ce_r) pix_r = ~pix_r;
    end

    // Drain in blanking and confirm nothing is left outstanding.
    for (int i = 0; i < 8; i++) step(0, 1, 1'(i % 2), 1, 0, '0, '0, '0);
    check("write_queue_drained", exp_wq.size(), 32'd0);
    check("read_queue_drained", exp_rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
